mc_path_payoff_core: RTL and testbench

Parametrised Monte Carlo payoff core, successor to the fixed 12-bit / 256-path / 8-day pricing core in the option-pricing datapath. It accepts simulated underlying prices streamed day-major: all paths for day 0, then all paths for day 1, and so on. It keeps a per-path running sum internally, so the path source never has to resend a day. At maturity it returns the mean payoff for European or Asian (arithmetic-average) call or put options.

---
 rtl/mc_pkg.sv | 27 ++
 rtl/mc_payoff_unit.sv | 21 ++
 rtl/mc_path_payoff_core.sv | 130 +++++++++++++
 tb/tb_mc_path_payoff_core.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and helpers for the Monte Carlo payoff core.
package mc_pkg;

  typedef enum logic [1:0] {
    EURO_CALL  = 2'd0,
    EURO_PUT   = 2'd1,
    ASIAN_CALL = 2'd2,
    ASIAN_PUT  = 2'd3
  } mc_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mc_state_t;

  // Ceiling log2, elaboration-time only; sizes index, sum and accumulator fields.
  function automatic int mc_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mc_payoff_unit.sv
// Clamped vanilla payoff: max(S-K,0) for calls, max(K-S,0) for puts.
module mc_payoff_unit #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_s,
  input  logic [W-1:0] i_k,
  input  logic         i_put,
  output logic [W-1:0] o_payoff
);

  // Subtract in the direction that can be positive, clamp otherwise.
  always_comb begin
    o_payoff = '0;
    if (i_put) begin
      if (i_k > i_s) o_payoff = i_k - i_s;
    end else begin
      if (i_s > i_k) o_payoff = i_s - i_k;
    end
  end

endmodule

// File: rtl/mc_path_payoff_core.sv
// Streams day-major path samples, keeps per-path running sums and returns
// the mean European/Asian call/put payoff at maturity.
module mc_path_payoff_core
  import mc_pkg::*;
#(
  parameter int W       = 12,
  parameter int N_PATHS = 256,
  parameter int N_DAYS  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] K,
  input  logic         in_valid,
  input  logic [W-1:0] in_path,
  output logic         in_ready,
  output logic         day_done,
  output logic         busy,
  output logic         price_valid,
  output logic [W-1:0] price
);

  localparam int LP = mc_log2(N_PATHS);
  localparam int LD = mc_log2(N_DAYS);
  localparam int SW = W + LD;
  localparam int AW = W + LP;

  mc_state_t         r_state, w_state_nxt;
  logic [LP-1:0]     r_path_idx;
  logic [LD-1:0]     r_day_idx;
  logic [W-1:0]      r_k;
  mc_mode_t          r_mode;
  logic [SW-1:0]     r_sum [N_PATHS];
  logic [W-1:0]      r_pay;
  logic              r_pay_vld;
  logic [AW-1:0]     r_acc;
  logic [W-1:0]      r_price;
  logic              r_day_done;
  logic              r_drain;

  logic              w_in_ready, w_accept, w_last_path, w_last_day;
  logic [SW-1:0]     w_sum_add, w_sum_wr, w_sum_avg;
  logic [W-1:0]      w_s, w_payoff;
  logic [AW-1:0]     w_acc_mean;

  assign w_accept    = in_valid && w_in_ready;
  assign w_last_path = (r_path_idx == LP'(N_PATHS - 1));
  assign w_last_day  = (r_day_idx == LD'(N_DAYS - 1));

  // Day 0 overwrites the slot, so stale sums from a previous run never leak in.
  assign w_sum_add = r_sum[r_path_idx] + SW'(in_path);
  assign w_sum_wr  = (r_day_idx == '0) ? SW'(in_path) : w_sum_add;
  assign w_sum_avg = w_sum_add >> LD;
  assign w_s       = r_mode[1] ? w_sum_avg[W-1:0] : in_path;
  assign w_acc_mean = r_acc >> LP;

  mc_payoff_unit #(.W(W)) u_payoff (
    .i_s      (w_s),
    .i_k      (r_k),
    .i_put    (r_mode[0]),
    .o_payoff (w_payoff)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = RUN;
      RUN: begin
        w_in_ready = 1'b1;
        if (in_valid && w_last_path && w_last_day) w_state_nxt = DRAIN;
      end
      DRAIN: if (r_drain) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM, indices, payoff pipeline and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_path_idx <= '0;
      r_day_idx  <= '0;
      r_k        <= '0;
      r_mode     <= EURO_CALL;
      r_pay      <= '0;
      r_pay_vld  <= 1'b0;
      r_acc      <= '0;
      r_price    <= '0;
      r_day_done <= 1'b0;
      r_drain    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_day_done <= w_accept && w_last_path;
      r_pay_vld  <= w_accept && w_last_day;
      r_pay      <= w_payoff;
      r_drain    <= (r_state == DRAIN) && !r_drain;
      if (r_state == IDLE && start) begin
        r_k        <= K;
        r_mode     <= mc_mode_t'(mode);
        r_path_idx <= '0;
        r_day_idx  <= '0;
        r_acc      <= '0;
        r_price    <= '0;
      end else begin
        if (w_accept) begin
          r_path_idx <= r_path_idx + LP'(1);
          if (w_last_path) r_day_idx <= r_day_idx + LD'(1);
        end
        if (r_pay_vld) r_acc <= r_acc + AW'(r_pay);
        if (r_state == DRAIN && r_drain) r_price <= w_acc_mean[W-1:0];
      end
    end
  end

  // Per-path running sum, read-modify-write in the accept cycle.
  always_ff @(posedge clk) begin
    if (w_accept) r_sum[r_path_idx] <= w_sum_wr;
  end

  assign in_ready    = w_in_ready;
  assign day_done    = r_day_done;
  assign busy        = (r_state == RUN) || (r_state == DRAIN);
  assign price_valid = (r_state == DONE);
  assign price       = r_price;

endmodule

// File: tb/tb_mc_path_payoff_core.sv
// Directed plus randomized bench for mc_path_payoff_core (W=12, 4 paths, 2 days).
module tb_mc_path_payoff_core;

  localparam int W  = 12;
  localparam int NP = 4;
  localparam int ND = 2;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [1:0]    mode;
  logic [W-1:0]  K, in_path;
  logic          in_ready, day_done, busy, price_valid;
  logic [W-1:0]  price;

  logic [W-1:0]  samp [NP*ND];
  int            nchk = 0;
  int            nfail = 0;

  always #5 clk = ~clk;

  mc_path_payoff_core #(.W(W), .N_PATHS(NP), .N_DAYS(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .K(K),
    .in_valid(in_valid), .in_path(in_path), .in_ready(in_ready),
    .day_done(day_done), .busy(busy), .price_valid(price_valid), .price(price)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: mean payoff over paths, straight from the pricing definition.
  function automatic logic [W-1:0] model(input logic [1:0] md, input logic [W-1:0] k);
    int acc, s, sum, pay, ki;
    acc = 0;
    ki  = int'(k);
    for (int p = 0; p < NP; p++) begin
      if (md[1]) begin
        sum = 0;
        for (int d = 0; d < ND; d++) sum += int'(samp[d*NP+p]);
        s = sum / ND;
      end else begin
        s = int'(samp[(ND-1)*NP+p]);
      end
      if (md[0]) pay = (ki > s) ? ki - s : 0;
      else       pay = (s > ki) ? s - ki : 0;
      acc += pay;
    end
    return W'(acc / NP);
  endfunction

  task automatic run(input logic [1:0] md, input logic [W-1:0] k, input bit gaps, input bit midstart);
    int idx, dd, cyc;
    logic [W-1:0] e;
    idx = 0; dd = 0; cyc = 0;
    e = model(md, k);
    @(negedge clk); start = 1'b1; mode = md; K = k;
    @(negedge clk); start = 1'b0; mode = 2'($urandom); K = W'($urandom);
    chk("in_ready_after_start", in_ready, 1);
    chk("busy_in_run", busy, 1);
    while (idx < NP*ND && cyc < 400) begin
      dd += int'(day_done);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_path  = samp[idx];
      start    = midstart && (cyc == 3);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("accept_count", idx, NP*ND);
    dd += int'(day_done);
    chk("day_done_last_day", day_done, 1);
    chk("in_ready_drain", in_ready, 0);
    chk("price_valid_early1", price_valid, 0);
    @(negedge clk);
    chk("price_valid_early2", price_valid, 0);
    @(negedge clk);
    chk("price_valid_t2", price_valid, 1);
    chk("price", price, e);
    chk("day_done_count", dd, ND);
    @(negedge clk);
    chk("price_valid_pulse", price_valid, 0);
    chk("busy_after", busy, 0);
    chk("price_held", price, e);
  endtask

  task automatic load_euro();
    samp = '{12'h111, 12'h7A5, 12'h000, 12'hFFF, 12'h400, 12'h200, 12'h500, 12'h300};
  endtask

  task automatic load_asian();
    samp = '{12'h200, 12'h400, 12'h300, 12'h600, 12'h400, 12'h400, 12'h100, 12'h200};
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; K = '0; in_valid = 1'b0; in_path = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_day_done", day_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_price_valid", price_valid, 0);
    chk("rst_price", price, 0);
    rst = 1'b0;

    load_euro();
    run(2'd0, 12'h300, 0, 0);
    chk("euro_call_const", price, 12'h0C0);
    run(2'd1, 12'h300, 0, 0);
    chk("euro_put_const", price, 12'h040);
    load_asian();
    run(2'd2, 12'h300, 0, 0);
    chk("asian_call_const", price, 12'h080);
    run(2'd2, 12'h300, 1, 0);
    chk("asian_gaps_const", price, 12'h080);

    // in_valid held high in IDLE must not advance anything
    @(negedge clk); in_valid = 1'b1; in_path = 12'hFFF;
    for (int i = 0; i < 4; i++) begin
      chk("idle_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    run(2'd2, 12'h300, 0, 0);
    chk("asian_after_idle_valid", price, 12'h080);
    run(2'd2, 12'h300, 0, 1);
    chk("asian_mid_start", price, 12'h080);

    // reset after three accepts
    load_euro();
    @(negedge clk); start = 1'b1; mode = 2'd0; K = 12'h300;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_path = samp[i];
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_day_done", day_done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_price_valid", price_valid, 0);
    chk("midrst_price", price, 0);
    run(2'd0, 12'h300, 0, 0);
    chk("euro_after_rst", price, 12'h0C0);

    // extremes
    for (int i = 0; i < NP*ND; i++) samp[i] = 12'hFFF;
    run(2'd2, 12'h000, 0, 0);
    chk("max_asian_call", price, 12'hFFF);
    for (int i = 0; i < NP*ND; i++) samp[i] = 12'h000;
    run(2'd1, 12'hFFF, 0, 0);
    chk("max_euro_put", price, 12'hFFF);

    // randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NP*ND; i++) samp[i] = W'($urandom);
      run(2'($urandom), W'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
